apb4_watchdog: RTL and testbench

//  APB4-slave watchdog timer. Key-protected registers configure a prescaled up-counter, which

---
 rtl/wdg_pkg.sv | 38 +++
 rtl/wdg_tick_gen.sv | 64 ++++++
 rtl/apb4_watchdog.sv | 150 +++++++++++++++
 tb/tb_apb4_watchdog.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/wdg_pkg.sv
// Shared definitions for the APB4 watchdog: register map, unlock key and
// CTRL/STAT bit layout.
package wdg_pkg;

  localparam int unsigned APB_DATA_W   = 32;
  localparam int unsigned REG_IDX_W    = 3;
  localparam int unsigned CTRL_W       = 3;

  localparam logic [APB_DATA_W-1:0] WDG_MAGIC_KEY = 32'h5F37_59DF;

  // Word index taken from paddr[4:2].
  typedef enum logic [REG_IDX_W-1:0] {
    REG_CTRL = 3'd0,
    REG_PSCR = 3'd1,
    REG_CNT  = 3'd2,
    REG_CMP  = 3'd3,
    REG_STAT = 3'd4,
    REG_KEY  = 3'd5,
    REG_FEED = 3'd6,
    REG_NONE = 3'd7
  } reg_idx_e;

  localparam int unsigned CTRL_OVIE   = 0;
  localparam int unsigned CTRL_CLKSEL = 1;
  localparam int unsigned CTRL_EN     = 2;
  localparam int unsigned STAT_OVIF   = 0;

  typedef struct packed {
    logic en;      // bit 2
    logic clksel;  // bit 1
    logic ovie;    // bit 0
  } ctrl_t;

  function automatic logic is_protected(input reg_idx_e idx);
    return idx inside {REG_CTRL, REG_PSCR, REG_CMP, REG_FEED};
  endfunction

endpackage

// File: rtl/wdg_tick_gen.sv
// Count-tick generator: synchronises rtc_clk_i, detects its rising edge,
// selects the tick source and divides it by (PSCR+1).
module wdg_tick_gen
  import wdg_pkg::*;
#(
  parameter int unsigned PSCR_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              rtc_clk_i,
  input  logic              en_i,
  input  logic              clksel_i,
  input  logic              clr_i,
  input  logic [PSCR_W-1:0] pscr_i,
  output logic              cnt_tick_o
);

  logic [2:0]        rtc_sync_q, rtc_sync_d;
  logic              clksel_q, clksel_d;
  logic [PSCR_W-1:0] pcnt_q, pcnt_d;
  logic              rtc_tick;
  logic              src_tick;
  logic              sel_change;
  logic              pcnt_hit;

  // Bits [1:0] are the two-flop synchroniser, bit [2] remembers the previous
  // synchronised level for edge detection.
  assign rtc_sync_d = {rtc_sync_q[1:0], rtc_clk_i};
  assign rtc_tick   = rtc_sync_q[1] & ~rtc_sync_q[2];
  assign src_tick   = clksel_i ? rtc_tick : 1'b1;
  assign sel_change = clksel_i ^ clksel_q;
  assign pcnt_hit   = (pcnt_q == pscr_i);
  assign clksel_d   = clksel_i;

  assign cnt_tick_o = en_i & src_tick & pcnt_hit & ~clr_i & ~sel_change;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pcnt_d = pcnt_q;
    if (clr_i || sel_change) begin
      pcnt_d = '0;
    end else if (en_i && src_tick) begin
      pcnt_d = pcnt_hit ? '0 : pcnt_q + PSCR_W'(1);
    end
  end

  // NOTE: reset is synchronous here, so rst_n_i is only tested inside the
  // clocked block and never appears in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rtc_sync_q <= '0;
      clksel_q   <= 1'b0;
      pcnt_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // sample their inputs from the same pre-edge values.
      rtc_sync_q <= rtc_sync_d;
      clksel_q   <= clksel_d;
      pcnt_q     <= pcnt_d;
    end
  end

endmodule

// File: rtl/apb4_watchdog.sv
// APB4 watchdog: key-protected register file, prescaled up-counter with
// compare, overflow flag/interrupt and a one-cycle reset request on a second
// unserviced overflow.
module apb4_watchdog
  import wdg_pkg::*;
#(
  parameter int unsigned APB_ADDR_W = 32,
  parameter int unsigned PSCR_W     = 20,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [APB_ADDR_W-1:0] paddr_i,
  input  logic [2:0]            pprot_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [31:0]           pwdata_i,
  input  logic [3:0]            pstrb_i,
  output logic                  pready_o,
  output logic [31:0]           prdata_o,
  output logic                  pslverr_o,
  input  logic                  rtc_clk_i,
  output logic                  irq_o,
  output logic                  rst_o
);

  ctrl_t             ctrl_q, ctrl_d;
  logic [PSCR_W-1:0] pscr_q, pscr_d;
  logic [CNT_W-1:0]  cmp_q,  cmp_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic              ovif_q, ovif_d;
  logic              unlock_q, unlock_d;
  logic              rst_q,  rst_d;

  logic     access, wr_en, rd_en;
  logic     prot_wr, wr_ok, feed;
  logic     cnt_tick, cnt_hit, overflow;
  logic     stat_clr;
  reg_idx_e idx;
  logic     unused_ok;

  // pprot, pstrb and the undecoded address bits have no effect.
  assign unused_ok = ^{pprot_i, pstrb_i, paddr_i[APB_ADDR_W-1:5], paddr_i[1:0]};

  assign idx     = reg_idx_e'(paddr_i[4:2]);
  assign access  = psel_i & penable_i;
  assign wr_en   = access & pwrite_i;
  assign rd_en   = access & ~pwrite_i;
  assign prot_wr = wr_en & is_protected(idx);
  assign wr_ok   = prot_wr & unlock_q;
  assign feed    = wr_ok & (idx == REG_FEED);

  assign pready_o  = 1'b1;
  assign pslverr_o = prot_wr & ~unlock_q;

  wdg_tick_gen #(
    .PSCR_W (PSCR_W)
  ) u_tick_gen (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .rtc_clk_i  (rtc_clk_i),
    .en_i       (ctrl_q.en),
    .clksel_i   (ctrl_q.clksel),
    .clr_i      (feed),
    .pscr_i     (pscr_q),
    .cnt_tick_o (cnt_tick)
  );

  // A feed in the same cycle as a tick wins: no increment and no overflow.
  assign cnt_hit  = (cnt_q == cmp_q);
  assign overflow = cnt_tick & cnt_hit & ~feed;
  assign stat_clr = (rd_en && idx == REG_STAT) ||
                    (wr_en && idx == REG_STAT && pwdata_i[STAT_OVIF]);
  assign rst_d    = overflow & ovif_q;

  always_comb begin
    ctrl_d   = ctrl_q;
    pscr_d   = pscr_q;
    cmp_d    = cmp_q;
    unlock_d = unlock_q;
    cnt_d    = cnt_q;
    ovif_d   = ovif_q;

    // Any KEY write re-arms or disarms the lock; protected writes consume it.
    if (wr_en && idx == REG_KEY) begin
      unlock_d = (pwdata_i == WDG_MAGIC_KEY);
    end else if (prot_wr) begin
      unlock_d = 1'b0;
    end

    if (wr_ok) begin
      case (idx)
        REG_CTRL: ctrl_d = ctrl_t'(pwdata_i[CTRL_W-1:0]);
        REG_PSCR: pscr_d = pwdata_i[PSCR_W-1:0];
        REG_CMP:  cmp_d  = CNT_W'(pwdata_i);
        default:  ;
      endcase
    end

    if (feed) begin
      cnt_d = '0;
    end else if (cnt_tick) begin
      cnt_d = cnt_hit ? '0 : cnt_q + CNT_W'(1);
    end

    if (stat_clr) begin
      ovif_d = 1'b0;
    end
    if (overflow) begin
      ovif_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ctrl_q   <= '0;
      pscr_q   <= '0;
      cmp_q    <= '0;
      cnt_q    <= '0;
      ovif_q   <= 1'b0;
      unlock_q <= 1'b0;
      rst_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      pscr_q   <= pscr_d;
      cmp_q    <= cmp_d;
      cnt_q    <= cnt_d;
      ovif_q   <= ovif_d;
      unlock_q <= unlock_d;
      rst_q    <= rst_d;
    end
  end

  assign irq_o = ctrl_q.ovie & ovif_q;
  assign rst_o = rst_q;

  always_comb begin
    prdata_o = '0;
    case (idx)
      REG_CTRL: prdata_o = 32'(ctrl_q);
      REG_PSCR: prdata_o = 32'(pscr_q);
      REG_CNT:  prdata_o = 32'(cnt_q);
      REG_CMP:  prdata_o = 32'(cmp_q);
      REG_STAT: prdata_o = 32'(ovif_q);
      default:  prdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_apb4_watchdog.sv
// Directed bench for apb4_watchdog: reset state, key lock, counting,
// overflow/irq, reset request, feeding and the rtc tick source.
module tb_apb4_watchdog;

  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_PSCR = 32'h04;
  localparam logic [31:0] A_CNT  = 32'h08;
  localparam logic [31:0] A_CMP  = 32'h0C;
  localparam logic [31:0] A_STAT = 32'h10;
  localparam logic [31:0] A_KEY  = 32'h14;
  localparam logic [31:0] A_FEED = 32'h18;
  localparam logic [31:0] A_UNM  = 32'h1C;
  localparam logic [31:0] MAGIC  = 32'h5F37_59DF;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] paddr_i = '0;
  logic [2:0]  pprot_i = '0;
  logic        psel_i = 1'b0;
  logic        penable_i = 1'b0;
  logic        pwrite_i = 1'b0;
  logic [31:0] pwdata_i = '0;
  logic [3:0]  pstrb_i = 4'hF;
  logic        pready_o;
  logic [31:0] prdata_o;
  logic        pslverr_o;
  logic        rtc_clk_i = 1'b0;
  logic        irq_o;
  logic        rst_o;
  logic        rtc_run = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  apb4_watchdog dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .paddr_i   (paddr_i),
    .pprot_i   (pprot_i),
    .psel_i    (psel_i),
    .penable_i (penable_i),
    .pwrite_i  (pwrite_i),
    .pwdata_i  (pwdata_i),
    .pstrb_i   (pstrb_i),
    .pready_o  (pready_o),
    .prdata_o  (prdata_o),
    .pslverr_o (pslverr_o),
    .rtc_clk_i (rtc_clk_i),
    .irq_o     (irq_o),
    .rst_o     (rst_o)
  );

  always #5 clk_i = ~clk_i;
  always #11 if (rtc_run) rtc_clk_i = ~rtc_clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All bus tasks start 1ns after an edge and return 1ns after the edge
  // that completes the access.
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                           output logic err);
    paddr_i = addr; pwdata_i = data; pwrite_i = 1'b1; psel_i = 1'b1; penable_i = 1'b0;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    #1 err = pslverr_o;
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    paddr_i = addr; pwrite_i = 1'b0; psel_i = 1'b1; penable_i = 1'b0;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    #1 data = prdata_o;
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  task automatic key_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    logic err;
    apb_write(A_KEY, MAGIC, err);
    apb_write(addr, data, err);
    check(tag, {31'd0, err}, 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n_i = 1'b0;
    repeat (cycles) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  logic [31:0] rd;
  logic        err;

  initial begin
    // ---------------- reset state ----------------
    @(posedge clk_i); #1;
    do_reset(40);
    for (int i = 0; i < 8; i++) begin
      apb_read(32'(i * 4), rd);
      check($sformatf("reset_rd_%0d", i), rd, 32'd0);
    end
    check("reset_irq", {31'd0, irq_o}, 32'd0);
    check("reset_rst", {31'd0, rst_o}, 32'd0);
    check("reset_pready", {31'd0, pready_o}, 32'd1);

    // ---------------- lock ----------------
    apb_write(A_CTRL, 32'd7, err);
    check("lock_err_nokey", {31'd0, err}, 32'd1);
    apb_read(A_CTRL, rd);
    check("lock_ctrl_unchanged", rd, 32'd0);
    key_write("lock_keyed_ctrl_err", A_CTRL, 32'd7);
    apb_read(A_CTRL, rd);
    check("lock_ctrl_7", rd, 32'd7);
    apb_write(A_CTRL, 32'd0, err);
    check("lock_err_consumed", {31'd0, err}, 32'd1);
    apb_read(A_CTRL, rd);
    check("lock_ctrl_still_7", rd, 32'd7);
    apb_write(A_KEY, 32'h1234_5678, err);
    apb_write(A_CMP, 32'd9, err);
    check("lock_err_badkey", {31'd0, err}, 32'd1);
    apb_write(A_FEED, 32'd0, err);
    check("lock_err_feed", {31'd0, err}, 32'd1);
    key_write("lock_ctrl_allones_err", A_CTRL, 32'hFFFF_FFFF);
    apb_read(A_CTRL, rd);
    check("ctrl_upper_bits_zero", rd, 32'd7);
    apb_write(A_UNM, 32'hDEAD_BEEF, err);
    check("unmapped_wr_err", {31'd0, err}, 32'd0);
    apb_read(A_UNM, rd);
    check("unmapped_rd", rd, 32'd0);
    apb_read(A_KEY, rd);
    check("key_rd_zero", rd, 32'd0);

    // ---------------- count / overflow / STAT read-clear ----------------
    do_reset(3);
    key_write("cnt_pscr", A_PSCR, 32'd3);
    key_write("cnt_cmp", A_CMP, 32'd5);
    key_write("cnt_ctrl", A_CTRL, 32'd5);        // enable commits at E0
    apb_read(A_CNT, rd);                         // sampled at E1
    check("cnt_e1", rd, 32'd0);
    apb_read(A_CNT, rd);                         // sampled at E3
    check("cnt_e3", rd, 32'd0);
    apb_read(A_CNT, rd);                         // sampled at E5 (after E4 tick)
    check("cnt_e5", rd, 32'd1);
    wait_cycles(17);                             // E23
    check("irq_before_ovf", {31'd0, irq_o}, 32'd0);
    wait_cycles(1);                              // E24
    check("irq_at_ovf", {31'd0, irq_o}, 32'd1);
    check("rst_first_ovf", {31'd0, rst_o}, 32'd0);
    apb_read(A_STAT, rd);
    check("stat_ovif_set", rd, 32'd1);
    check("irq_after_stat_rd", {31'd0, irq_o}, 32'd0);
    apb_read(A_STAT, rd);
    check("stat_ovif_clear", rd, 32'd0);

    // ---------------- reset request ----------------
    do_reset(3);
    key_write("rr_pscr", A_PSCR, 32'd3);
    key_write("rr_cmp", A_CMP, 32'd5);
    key_write("rr_ctrl", A_CTRL, 32'd5);         // E0
    wait_cycles(47);                             // E47
    check("rr_before", {31'd0, rst_o}, 32'd0);
    check("rr_irq_set", {31'd0, irq_o}, 32'd1);
    wait_cycles(1);                              // E48
    check("rr_pulse", {31'd0, rst_o}, 32'd1);
    wait_cycles(1);                              // E49
    check("rr_one_cycle", {31'd0, rst_o}, 32'd0);
    apb_write(A_STAT, 32'd1, err);
    check("stat_w1c_err", {31'd0, err}, 32'd0);
    check("stat_w1c_irq", {31'd0, irq_o}, 32'd0);
    rst_n_i = 1'b0;                              // mid-operation reset
    wait_cycles(1);
    check("midrst_rst_o", {31'd0, rst_o}, 32'd0);
    check("midrst_irq", {31'd0, irq_o}, 32'd0);
    rst_n_i = 1'b1;
    apb_read(A_CNT, rd);
    check("midrst_cnt", rd, 32'd0);
    apb_read(A_CTRL, rd);
    check("midrst_ctrl", rd, 32'd0);

    // ---------------- feed ----------------
    key_write("feed_pscr", A_PSCR, 32'd3);
    key_write("feed_cmp", A_CMP, 32'd5);
    key_write("feed_ctrl", A_CTRL, 32'd5);
    for (int i = 0; i < 5; i++) begin
      wait_cycles(12);
      key_write($sformatf("feed_%0d", i), A_FEED, 32'hA5A5_0000);
      check($sformatf("feed_irq_%0d", i), {31'd0, irq_o}, 32'd0);
    end
    apb_read(A_CNT, rd);
    check("feed_cnt_zero", rd, 32'd0);
    apb_read(A_STAT, rd);
    check("feed_no_ovif", rd, 32'd0);
    apb_read(A_FEED, rd);
    check("feed_rd_zero", rd, 32'd0);

    // ---------------- rtc tick source ----------------
    rtc_run = 1'b1;
    do_reset(3);
    key_write("rtc_pscr", A_PSCR, 32'd0);
    key_write("rtc_cmp", A_CMP, 32'd10);
    key_write("rtc_ctrl", A_CTRL, 32'd7);
    wait_cycles(20);
    check("rtc_no_ovf_yet", {31'd0, irq_o}, 32'd0);
    apb_read(A_CNT, rd);
    check("rtc_cnt_range", {31'd0, (rd >= 32'd7 && rd <= 32'd10)}, 32'd1);
    wait_cycles(15);
    check("rtc_ovf", {31'd0, irq_o}, 32'd1);
    rtc_run = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
